serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial add controller that time-shares a single 1-bit full-adder cell to compute W-bit sums. It accepts a pair of W-bit operands plus carry-in through a valid/ready handshake. It then steps the full adder LSB-first, one bit per clock, holding the carry in a flip-flop. The result is presented on a valid/ready output port. The block sits between an operand producer and a result consumer wherever area matters more than adder throughput.

## Interface
Parameters:
- W, 8, operand/result width in bits; legal range W >= 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand set present on a, b, cin.
- in_ready  output  1  block can accept operands; high iff state is IDLE.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result present; high iff state is DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  W  (a + b + cin) mod 2^W; defined only while out_valid=1.
- cout  output  1  carry out of bit W-1; defined only while out_valid=1.
- busy  output  1  high in RUN or DONE.

## Operation
- States:
  - IDLE: accept operands.
  - RUN: one bit per cycle.
  - DONE: hold result.
- IDLE:
  - On in_valid & in_ready at an edge: capture a, b into shift registers; carry <= cin; bit counter <= 0; go to RUN.
  - No capture when in_valid=0.
- RUN, each edge:
  - Full adder sees A=a_sh[0], B=b_sh[0], Cin=carry.
  - a_sh and b_sh shift right.
  - Sum bit enters sum_sh at MSB, shifting right.
  - carry <= fa Cout.
  - counter++.
  - When counter == W-1 at the edge, go to DONE.
- DONE:
  - sum = sum_sh; cout = carry; both stable.
  - On out_valid & out_ready at an edge, go to IDLE.
- Operand inputs are don't-care after the capture edge. Changes on a/b/cin during RUN/DONE have no effect.
- in_valid during RUN/DONE is ignored (in_ready=0); no queuing.
- Overflow is not an error: the result wraps mod 2^W and the carry appears on cout.
- W=1: RUN lasts exactly one cycle.
- Counter width: max(1, clog2(W)) bits. It never wraps because the RUN exit happens at W-1.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state IDLE, so in_ready=1, out_valid=0, busy=0.
  - sum_sh=0, carry=0, so sum=0 and cout=0.
  - Counter and operand shift registers = 0.
- Latency: out_valid rises exactly W clock edges after the accepting edge.
- Minimum op period: W+2 cycles (W RUN, 1 DONE, 1 IDLE) with out_ready held high and in_valid held high.
- Backpressure: out_ready low holds DONE indefinitely. out_valid, sum and cout are held unchanged.
- Reset mid-operation (rst_n low in RUN or DONE):
  - Immediate return to IDLE; the partial result is discarded; no out_valid pulse.
  - The first accept after rst_n rises is processed normally.
- in_ready and out_valid are decoded from the state register only, with no combinational path from in_valid or out_ready.

## Structure
- Shared package serial_add_pkg holds:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default width constant SA_W=8.
- Exactly one sub-module instance: the team's existing fa full-adder cell (A, B, Cin → Sum, Cout), fed from shift-register LSBs and the carry flop.
- No other arithmetic in the block: sum bits come only from fa.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs. Required: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Basic add, W=8: a=8'h5A, b=8'h3C, cin=0. Required: out_valid exactly 8 edges after accept; sum=8'h96, cout=0.
- Carry chain, W=8:
  - a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 → sum=8'hFF, cout=1.
- Backpressure, W=8: out_ready=0 for 5 cycles in DONE while in_valid pulses with new operands. Required: sum/cout/out_valid unchanged, in_ready=0, pulses ignored; next result matches the original operands.
- Mid-op reset: assert rst_n=0 on the 3rd RUN cycle. Required: immediate IDLE, no out_valid. Next op a=8'h10, b=8'h20, cin=1 → sum=8'h31, cout=0.
- Exhaustive sweep, W=4:
  - Run all 512 {a,b,cin} combos with in_valid and out_ready held high.
  - Scoreboard compares {cout,sum} against a+b+cin.
  - Required: all pass, accept-to-accept period = 6 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add controller: state encoding and
// default operand width.
package serial_add_pkg;

  localparam int SA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl; slave is the adder side.
interface serial_add_ctrl_if #(
  parameter int W = serial_add_pkg::SA_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Team 1-bit full-adder cell, time-shared by serial_add_ctrl.
module fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures a W-bit operand pair, steps one fa
// cell LSB-first for W cycles, then holds the result on a valid/ready port.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int W = SA_W
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state, state_nx;
  logic [W-1:0]  a_sh, b_sh, sum_sh, sum_nx;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          fa_s, fa_co;

  fa u_fa (
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry),
    .Sum  (fa_s),
    .Cout (fa_co)
  );

  // New sum bit enters at the MSB so after W steps bit 0 holds the LSB result.
  always_comb begin
    sum_nx        = sum_sh >> 1;
    sum_nx[W-1]   = fa_s;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nx = RUN;
      RUN:     if (cnt == LAST)   state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nx;
          carry  <= fa_co;
          // Hold at the last index so the counter never wraps.
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_sh;
  assign bus.cout      = carry;

endmodule
